// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instmem and queues fetched words toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Word alignment is enforced even if the parameter is misconfigured.
    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(QDEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [31:0] pc_q, pc_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    logic [31:0] inst_q [QDEPTH];
    logic [31:0] inst_d [QDEPTH];
    logic [31:0] addr_q [QDEPTH];
    logic [31:0] addr_d [QDEPTH];

    logic push;
    logic pop;
    logic full;

    always_comb begin
        full = (count_q == cnt_t'(QDEPTH));
        pop  = out_valid & out_ready;
        push = fetch_en & ~br_taken & (~full | pop);
    end

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (br_taken) begin
            // Redirect wins: the in-flight word is dropped and the queue is emptied.
            pc_d     = {br_target[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < int'(QDEPTH); i++) begin
            inst_d[i] = inst_q[i];
            addr_d[i] = addr_q[i];
        end
        if (push) begin
            inst_d[wr_ptr_q] = imem_inst;
            addr_d[wr_ptr_q] = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= ResetPcAligned;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                inst_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                inst_q[i] <= inst_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

    always_comb begin
        imem_addr = pc_q;
        out_valid = (count_q != '0);
        out_inst  = inst_q[rd_ptr_q];
        out_pc    = addr_q[rd_ptr_q];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        stall;

    always_comb begin
        stall       = fetch_en & ~br_taken & full & ~pop;
        fetch_cnt_d = push     ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        stall_cnt_d = stall    ? stall_cnt_q + 32'd1 : stall_cnt_q;
        flush_cnt_d = br_taken ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        perf_fetch_cnt = fetch_cnt_q;
        perf_stall_cnt = stall_cnt_q;
        perf_flush_cnt = flush_cnt_q;
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: streaming, back-pressure, redirect, fetch stall,
// PC wrap-around and asynchronous reset; perf counters checked when FETCH_PERF_CNT_EN is set.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        out_ready;
    logic        br_taken;
    logic [31:0] br_target;

    logic [31:0] imem_addr, imem_inst, out_inst, out_pc;
    logic        out_valid;

    logic [31:0] hi_imem_addr, hi_imem_inst, hi_out_inst, hi_out_pc;
    logic        hi_out_valid;
    logic        hi_br_taken;
    logic [31:0] hi_br_target;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
    logic [31:0] hi_perf_fetch_cnt, hi_perf_stall_cnt, hi_perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hE1A0_0000;
    endfunction

    assign imem_inst    = mem_word(imem_addr);
    assign hi_imem_inst = mem_word(hi_imem_addr);

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .imem_addr (imem_addr),
        .imem_inst (imem_inst),
        .br_taken  (br_taken),
        .br_target (br_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    inst_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .QDEPTH   (2)
    ) dut_hi (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .imem_addr (hi_imem_addr),
        .imem_inst (hi_imem_inst),
        .br_taken  (hi_br_taken),
        .br_target (hi_br_target),
        .out_valid (hi_out_valid),
        .out_ready (out_ready),
        .out_inst  (hi_out_inst),
        .out_pc    (hi_out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (hi_perf_fetch_cnt),
        .perf_stall_cnt (hi_perf_stall_cnt),
        .perf_flush_cnt (hi_perf_flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        fetch_en     = 1'b1;
        out_ready    = 1'b1;
        br_taken     = 1'b0;
        br_target    = 32'h0;
        hi_br_taken  = 1'b0;
        hi_br_target = 32'h0;

        // Reset state.
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_inst", out_inst, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_hi_addr", hi_imem_addr, 32'hFFFF_FFF8);
        rst = 1'b1;

        // Streaming with ready held high: one word per cycle, in order.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("strm_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("strm_pc%0d", k), out_pc, 32'(4 * k));
            check($sformatf("strm_inst%0d", k), out_inst, mem_word(32'(4 * k)));
            if (k < 3) begin
                check($sformatf("wrap_pc%0d", k), hi_out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
            end
        end

        // Back-pressure: two pushes then the PC holds.
        do_reset();
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_pc", out_pc, 32'h0);
        check("bp_inst", out_inst, mem_word(32'h0));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_pc1", out_pc, 32'h4);
        check("bp_rel_addr1", imem_addr, 32'hC);
        @(negedge clk);
        check("bp_rel_pc2", out_pc, 32'h8);
        check("bp_rel_addr2", imem_addr, 32'h10);

        // Redirect with a full queue.
        out_ready = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        @(negedge clk);
        br_taken  = 1'b0;
        check("br_valid", 32'(out_valid), 32'd0);
        check("br_addr", imem_addr, 32'h100);
        out_ready = 1'b1;
        @(negedge clk);
        check("br_valid2", 32'(out_valid), 32'd1);
        check("br_pc", out_pc, 32'h100);
        check("br_inst", out_inst, mem_word(32'h100));
        @(negedge clk);
        check("br_pc2", out_pc, 32'h104);

        // Fetch stall: queue drains, PC holds, then resumes.
        fetch_en = 1'b0;
        @(negedge clk);
        check("fe_valid", 32'(out_valid), 32'd0);
        check("fe_addr", imem_addr, 32'h108);
        @(negedge clk);
        check("fe_addr2", imem_addr, 32'h108);
        fetch_en = 1'b1;
        @(negedge clk);
        check("fe_valid2", 32'(out_valid), 32'd1);
        check("fe_pc", out_pc, 32'h108);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_hi_addr", hi_imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
        check("arst_fcnt", perf_fetch_cnt, 32'd0);
        check("arst_scnt", perf_stall_cnt, 32'd0);
        check("arst_bcnt", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("arst_pc", out_pc, 32'h24);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, 32'd10);
        check("perf_stall0", perf_stall_cnt, 32'd0);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("perf_stall", perf_stall_cnt, 32'd3);
        check("perf_fetch2", perf_fetch_cnt, 32'd11);
        br_taken = 1'b1;
        @(negedge clk);
        br_taken = 1'b0;
        check("perf_flush", perf_flush_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
